ahb_lite_master_arbiter: RTL and testbench

- Two-master AHB-Lite arbiter/input stage in front of the system bus fabric: M0 (CPU) and M1 (DMA/debug) share one AHB-Lite master port.
- Each master gets a one-deep address-phase holding register; a master that loses arbitration is stalled through its own HREADY until its transfer is issued.
- Output port connects to the existing bus master interface (HADDR/HTRANS/HWRITE/HSIZE/HWDATA out, HREADY/HRDATA in).

---
 rtl/ahb_lite_master_arbiter.sv | 130 +++++++++++++
 tb/tb_ahb_lite_master_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master_arbiter.sv
// Two-master AHB-Lite input stage. Each master has a one-deep address-phase
// holding register. A master that loses arbitration is stalled through its own HREADY.
module ahb_lite_master_arbiter #(
    parameter bit RR = 1'b0,
    parameter int AW = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [AW-1:0] HADDR_M0,
    input  logic [AW-1:0] HADDR_M1,
    input  logic [1:0]    HTRANS_M0,
    input  logic [1:0]    HTRANS_M1,
    input  logic          HWRITE_M0,
    input  logic          HWRITE_M1,
    input  logic [2:0]    HSIZE_M0,
    input  logic [2:0]    HSIZE_M1,
    input  logic [31:0]   HWDATA_M0,
    input  logic [31:0]   HWDATA_M1,
    output logic          HREADY_M0,
    output logic          HREADY_M1,
    output logic [31:0]   HRDATA_M0,
    output logic [31:0]   HRDATA_M1,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [31:0]   HWDATA,
    input  logic          HREADY,
    input  logic [31:0]   HRDATA,
    output logic [1:0]    GNT
);

    localparam int NUM_M = 2;

    logic [NUM_M-1:0][AW-1:0] live_addr;
    logic [NUM_M-1:0]         live_req;
    logic [NUM_M-1:0]         live_write;
    logic [NUM_M-1:0][2:0]    live_size;
    logic [NUM_M-1:0][31:0]   live_wdata;

    logic [NUM_M-1:0]         pend_v;
    logic [NUM_M-1:0][AW-1:0] pend_addr;
    logic [NUM_M-1:0]         pend_write;
    logic [NUM_M-1:0][2:0]    pend_size;

    logic [NUM_M-1:0][AW-1:0] src_addr;
    logic [NUM_M-1:0]         src_write;
    logic [NUM_M-1:0][2:0]    src_size;
    logic [NUM_M-1:0]         req;
    logic [NUM_M-1:0]         hready_m;
    logic [NUM_M-1:0]         capture;

    logic aown_q, dval_q, down_q, last_q;
    logic owner;
    logic unused_ok;

    assign live_addr  = {HADDR_M1, HADDR_M0};
    assign live_req   = {HTRANS_M1[1], HTRANS_M0[1]};
    assign live_write = {HWRITE_M1, HWRITE_M0};
    assign live_size  = {HSIZE_M1, HSIZE_M0};
    assign live_wdata = {HWDATA_M1, HWDATA_M0};
    assign unused_ok  = HTRANS_M0[0] ^ HTRANS_M1[0];

    for (genvar g = 0; g < NUM_M; g++) begin : g_master
        assign src_addr[g]  = pend_v[g] ? pend_addr[g]  : live_addr[g];
        assign src_write[g] = pend_v[g] ? pend_write[g] : live_write[g];
        assign src_size[g]  = pend_v[g] ? pend_size[g]  : live_size[g];
        assign req[g]       = pend_v[g] | live_req[g];
        assign hready_m[g]  = pend_v[g] ? 1'b0 :
                              (dval_q && (down_q == 1'(g))) ? HREADY : 1'b1;
        // Capture both the arbitration loser and anyone presenting into a waited bus.
        assign capture[g]   = hready_m[g] & live_req[g] & ~pend_v[g] &
                              ~((owner == 1'(g)) & HREADY);
    end

    always_comb begin
        owner = aown_q;
        if (HREADY) begin
            if (req[0] && req[1])
                owner = RR ? ~last_q : 1'b0;
            else if (req[0])
                owner = 1'b0;
            else if (req[1])
                owner = 1'b1;
        end
    end

    // SEQ is forwarded as NONSEQ: bursts leave this block as single transfers.
    assign HTRANS    = req[owner] ? 2'b10 : 2'b00;
    assign HADDR     = src_addr[owner];
    assign HWRITE    = src_write[owner];
    assign HSIZE     = src_size[owner];
    assign GNT       = owner ? 2'b10 : 2'b01;
    assign HWDATA    = live_wdata[down_q];
    assign HREADY_M0 = hready_m[0];
    assign HREADY_M1 = hready_m[1];
    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            aown_q <= 1'b0;
            dval_q <= 1'b0;
            down_q <= 1'b0;
            last_q <= 1'b1;
        end else if (HREADY) begin
            aown_q <= owner;
            dval_q <= HTRANS[1];
            down_q <= owner;
            if (HTRANS[1])
                last_q <= owner;
        end
    end

    always_ff @(posedge HCLK) begin
        for (int m = 0; m < NUM_M; m++) begin
            if (HRESET) begin
                pend_v[m] <= 1'b0;
            end else if (capture[m]) begin
                pend_v[m]     <= 1'b1;
                pend_addr[m]  <= live_addr[m];
                pend_write[m] <= live_write[m];
                pend_size[m]  <= live_size[m];
            end else if (HREADY && (owner == 1'(m))) begin
                pend_v[m] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Bench for ahb_lite_master_arbiter: fixed-priority and round-robin instances share
// stimulus; a transaction-level model is compared every cycle, plus literal checks.
module tb_ahb_lite_master_arbiter;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic        w;
        logic [2:0]  s;
    } xfer_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic [31:0] m_addr [2];
    logic [1:0]  m_trans[2];
    logic        m_write[2];
    logic [2:0]  m_size [2];
    logic [31:0] m_wdata[2];

    logic        hready_m0_o[2], hready_m1_o[2];
    logic [31:0] hrdata_m0_o[2], hrdata_m1_o[2];
    logic [31:0] haddr_o[2];
    logic [1:0]  htrans_o[2];
    logic        hwrite_o[2];
    logic [2:0]  hsize_o[2];
    logic [31:0] hwdata_o[2];
    logic [1:0]  gnt_o[2];

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_master_arbiter #(.RR(1'b0), .AW(32)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR_M0(m_addr[0]), .HADDR_M1(m_addr[1]),
        .HTRANS_M0(m_trans[0]), .HTRANS_M1(m_trans[1]),
        .HWRITE_M0(m_write[0]), .HWRITE_M1(m_write[1]),
        .HSIZE_M0(m_size[0]), .HSIZE_M1(m_size[1]),
        .HWDATA_M0(m_wdata[0]), .HWDATA_M1(m_wdata[1]),
        .HREADY_M0(hready_m0_o[0]), .HREADY_M1(hready_m1_o[0]),
        .HRDATA_M0(hrdata_m0_o[0]), .HRDATA_M1(hrdata_m1_o[0]),
        .HADDR(haddr_o[0]), .HTRANS(htrans_o[0]), .HWRITE(hwrite_o[0]),
        .HSIZE(hsize_o[0]), .HWDATA(hwdata_o[0]),
        .HREADY(HREADY), .HRDATA(HRDATA), .GNT(gnt_o[0])
    );

    ahb_lite_master_arbiter #(.RR(1'b1), .AW(32)) dut1 (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR_M0(m_addr[0]), .HADDR_M1(m_addr[1]),
        .HTRANS_M0(m_trans[0]), .HTRANS_M1(m_trans[1]),
        .HWRITE_M0(m_write[0]), .HWRITE_M1(m_write[1]),
        .HSIZE_M0(m_size[0]), .HSIZE_M1(m_size[1]),
        .HWDATA_M0(m_wdata[0]), .HWDATA_M1(m_wdata[1]),
        .HREADY_M0(hready_m0_o[1]), .HREADY_M1(hready_m1_o[1]),
        .HRDATA_M0(hrdata_m0_o[1]), .HRDATA_M1(hrdata_m1_o[1]),
        .HADDR(haddr_o[1]), .HTRANS(htrans_o[1]), .HWRITE(hwrite_o[1]),
        .HSIZE(hsize_o[1]), .HWDATA(hwdata_o[1]),
        .HREADY(HREADY), .HRDATA(HRDATA), .GNT(gnt_o[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level model (index i: 0 = fixed, 1 = round-robin)
    xfer_t held[2][2], held_n[2][2];
    int    aown[2], aown_n[2], downer[2], downer_n[2], last[2], last_n[2];
    bit    dvalid[2], dvalid_n[2];
    bit    model_ok = 1'b0;

    always @(negedge HCLK) begin
        for (int i = 0; i < 2; i++) begin
            xfer_t live[2], cand[2];
            bit    rdy[2];
            int    nreq, win;
            for (int x = 0; x < 2; x++) begin
                live[x].v = m_trans[x][1];
                live[x].a = m_addr[x];
                live[x].w = m_write[x];
                live[x].s = m_size[x];
                cand[x]   = held[i][x].v ? held[i][x] : live[x];
                rdy[x]    = held[i][x].v ? 1'b0 :
                            (dvalid[i] && downer[i] == x) ? HREADY : 1'b1;
            end
            nreq = int'(cand[0].v) + int'(cand[1].v);
            if (!HREADY || nreq == 0) win = aown[i];
            else if (nreq == 1)       win = cand[0].v ? 0 : 1;
            else                      win = (i == 1) ? 1 - last[i] : 0;

            if (model_ok) begin
                chk($sformatf("rr%0d_htrans", i), htrans_o[i], cand[win].v ? 2 : 0);
                chk($sformatf("rr%0d_gnt", i), gnt_o[i], 1 << win);
                if (cand[win].v) begin
                    chk($sformatf("rr%0d_haddr", i), haddr_o[i], cand[win].a);
                    chk($sformatf("rr%0d_hwrite", i), hwrite_o[i], cand[win].w);
                    chk($sformatf("rr%0d_hsize", i), hsize_o[i], cand[win].s);
                end
                chk($sformatf("rr%0d_hready_m0", i), hready_m0_o[i], rdy[0]);
                chk($sformatf("rr%0d_hready_m1", i), hready_m1_o[i], rdy[1]);
                chk($sformatf("rr%0d_hrdata_m0", i), hrdata_m0_o[i], HRDATA);
                chk($sformatf("rr%0d_hrdata_m1", i), hrdata_m1_o[i], HRDATA);
                if (dvalid[i])
                    chk($sformatf("rr%0d_hwdata", i), hwdata_o[i], m_wdata[downer[i]]);
            end

            held_n[i]   = held[i];
            aown_n[i]   = aown[i];
            dvalid_n[i] = dvalid[i];
            downer_n[i] = downer[i];
            last_n[i]   = last[i];
            if (HREADY) begin
                aown_n[i]   = win;
                dvalid_n[i] = cand[win].v;
                downer_n[i] = win;
                if (cand[win].v) last_n[i] = win;
                held_n[i][win].v = 1'b0;
            end
            for (int x = 0; x < 2; x++)
                if (rdy[x] && live[x].v && !held[i][x].v && !(win == x && HREADY))
                    held_n[i][x] = live[x];
        end
    end

    always @(posedge HCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (HRESET) begin
                held[i][0].v <= 1'b0;
                held[i][1].v <= 1'b0;
                aown[i]      <= 0;
                dvalid[i]    <= 1'b0;
                downer[i]    <= 0;
                last[i]      <= 1;
            end else begin
                held[i]   <= held_n[i];
                aown[i]   <= aown_n[i];
                dvalid[i] <= dvalid_n[i];
                downer[i] <= downer_n[i];
                last[i]   <= last_n[i];
            end
        end
        if (HRESET) model_ok <= 1'b1;
    end

    // ---------------- directed stimulus with literal expectations
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    int n0, n1;

    initial begin
        HRESET = 1'b1;
        HREADY = 1'b1;
        HRDATA = 32'h0;
        for (int x = 0; x < 2; x++) begin
            m_addr[x] = 32'h0; m_trans[x] = 2'b00; m_write[x] = 1'b0;
            m_size[x] = 3'd2;  m_wdata[x] = 32'h0;
        end
        tick(); tick();
        HRESET = 1'b0;

        // reset / idle
        for (int k = 0; k < 10; k++) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                chk("idle_htrans", htrans_o[i], 0);
                chk("idle_hready_m0", hready_m0_o[i], 1);
                chk("idle_hready_m1", hready_m1_o[i], 1);
                chk("idle_gnt", gnt_o[i], 2'b01);
            end
            tick();
        end

        // uncontended M1 read
        m_trans[1] = 2'b10; m_addr[1] = 32'h2000_0010; m_write[1] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("m1_haddr", haddr_o[i], 32'h2000_0010);
            chk("m1_htrans", htrans_o[i], 2'b10);
            chk("m1_gnt", gnt_o[i], 2'b10);
        end
        tick();
        m_trans[1] = 2'b00; HRDATA = 32'hA5A5_0001;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("m1_data_hready", hready_m1_o[i], 1);
            chk("m1_hrdata", hrdata_m1_o[i], 32'hA5A5_0001);
        end
        tick();

        // collision: M0 write vs M1 read
        m_trans[0] = 2'b10; m_addr[0] = 32'h0000_0100; m_write[0] = 1'b1;
        m_trans[1] = 2'b10; m_addr[1] = 32'h4000_0000; m_write[1] = 1'b0;
        m_wdata[1] = 32'hBAD0_BAD0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("col_t_gnt", gnt_o[i], 2'b01);
            chk("col_t_haddr", haddr_o[i], 32'h0000_0100);
        end
        tick();
        m_trans[0] = 2'b00; m_trans[1] = 2'b00; m_wdata[0] = 32'hDEAD_0000;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("col_t1_hready_m1", hready_m1_o[i], 0);
            chk("col_t1_haddr", haddr_o[i], 32'h4000_0000);
            chk("col_t1_htrans", htrans_o[i], 2'b10);
            chk("col_t1_gnt", gnt_o[i], 2'b10);
            chk("col_t1_hwdata", hwdata_o[i], 32'hDEAD_0000);
        end
        tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("col_t2_hready_m1", hready_m1_o[i], 1);
            chk("col_t2_htrans", htrans_o[i], 2'b00);
        end
        tick();

        // continuous contention: round-robin alternates, fixed priority starves M1
        m_trans[0] = 2'b10; m_addr[0] = 32'h0000_1000; m_write[0] = 1'b0;
        m_trans[1] = 2'b10; m_addr[1] = 32'h0000_2000; m_write[1] = 1'b0;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_gnt", gnt_o[1], (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("fp_gnt", gnt_o[0], 2'b01);
            if (htrans_o[1] == 2'b10) begin
                if (gnt_o[1] == 2'b01) n0++;
                else n1++;
            end
            tick();
        end
        chk("rr_m0_count", n0, 4);
        chk("rr_m1_count", n1, 4);
        m_trans[0] = 2'b00; m_trans[1] = 2'b00;
        tick(); tick(); tick();

        // waited bus: fabric holds HREADY low during M0 data phase
        m_trans[0] = 2'b10; m_addr[0] = 32'h0000_0030; m_write[0] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) chk("wait_a_gnt", gnt_o[i], 2'b01);
        tick();
        m_trans[0] = 2'b00;
        m_trans[1] = 2'b10; m_addr[1] = 32'h4000_0008; m_write[1] = 1'b0;
        HREADY = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("wait_b_gnt", gnt_o[i], 2'b01);
            chk("wait_b_hready_m0", hready_m0_o[i], 0);
        end
        tick();
        m_trans[1] = 2'b00;
        for (int k = 0; k < 2; k++) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                chk("wait_cd_gnt", gnt_o[i], 2'b01);
                chk("wait_cd_hready_m0", hready_m0_o[i], 0);
                chk("wait_cd_hready_m1", hready_m1_o[i], 0);
            end
            tick();
        end
        HREADY = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("wait_e_gnt", gnt_o[i], 2'b10);
            chk("wait_e_haddr", haddr_o[i], 32'h4000_0008);
            chk("wait_e_htrans", htrans_o[i], 2'b10);
            chk("wait_e_hready_m0", hready_m0_o[i], 1);
        end
        tick(); tick(); tick();

        // reset with a pending M1 transfer and an M0 data phase in flight
        m_trans[0] = 2'b10; m_addr[0] = 32'h0000_0500; m_write[0] = 1'b1;
        m_trans[1] = 2'b10; m_addr[1] = 32'h0000_0600; m_write[1] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) chk("rst_r1_gnt", gnt_o[i], 2'b01);
        tick();
        m_trans[0] = 2'b00; m_trans[1] = 2'b00; HRESET = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) chk("rst_r2_hready_m1", hready_m1_o[i], 0);
        tick();
        HRESET = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_r3_htrans", htrans_o[i], 2'b00);
            chk("rst_r3_hready_m0", hready_m0_o[i], 1);
            chk("rst_r3_hready_m1", hready_m1_o[i], 1);
            chk("rst_r3_gnt", gnt_o[i], 2'b01);
        end
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
